inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction source for the cpu core: drives its 32-bit Inst input, which is otherwise driven by a
//  bench. Holds a small program RAM loaded through a write port, then replays it one instruction per
//  clk. Run/halt/done control FSM. Emits NOP when not running.
// PARAMETERS
//  DEPTH     64            program RAM entries
//  ADDR_W    6             address width; DEPTH == 2**ADDR_W
//  NOP_INST  32'h0000_0000 word driven on inst_out when not issuing (sll $0,$0,0)
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  load_we    in   1       program RAM write enable
//  load_addr  in   ADDR_W  program RAM write address
//  load_data  in   32      program RAM write data
//  prog_len   in   ADDR_W  address of last instruction; sampled on accepted start
//  start      in   1       begin issue from address 0 (IDLE or DONE only)
//  halt       in   1       abort issue, return to IDLE
//  inst_out   out  32      instruction to cpu Inst port (registered)
//  inst_valid out  1       inst_out holds a program word
//  issue_addr out  ADDR_W  RAM address of word on inst_out
//  busy       out  1       state == RUN
//  done       out  1       state == DONE
//  load_err   out  1       one-cycle pulse: load_we rejected during RUN
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE.
//   - inst_out=NOP_INST; inst_valid, issue_addr, busy, done, load_err all 0.
//   - len register = 0. RAM contents are not reset.
//  FSM IDLE/RUN/DONE. Priority each edge: halt > start > normal progress.
//  IDLE:
//   - load_we writes RAM[load_addr] (sync).
//   - start -> RUN: len<=prog_len, inst_out<=RAM[0], issue_addr<=0, inst_valid<=1.
//  RUN:
//   - if issue_addr==len -> DONE, inst_out<=NOP_INST, inst_valid<=0.
//   - else issue_addr<=issue_addr+1 (ADDR_W wrap, mod DEPTH), inst_out<=RAM[issue_addr+1].
//   - start ignored. halt -> IDLE, NOP_INST/valid 0 on next edge.
//  DONE:
//   - behaves as IDLE for loads; done=1 held.
//   - start restarts as from IDLE. halt -> IDLE.
//  Latency: start accepted at edge k -> RAM[i] on inst_out after edge k+i for i=0..len;
//   NOP after edge k+len+1 -> exactly len+1 valid cycles. prog_len=DEPTH-1 issues every entry once.
//  Load during RUN: write dropped, load_err=1 for one cycle; issue stream unaffected.
//  Write-first: load_we and start on same edge with load_addr=0 -> inst_out = new load_data.
//  prog_len changes after start have no effect until the next start.
//  Reset mid-RUN: immediate return to reset values; RAM retained; a new start replays it from 0.
// CONFIGURATION
//  IFU_ISSUE_COUNT_EN defined:
//   - adds output issue_cnt[31:0]: count of valid cycles issued.
//   - cleared on reset and on accepted start; saturates at 32'hFFFF_FFFF.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Load 0x20010001,0x20020001,0x00210820 at 0..2, prog_len=2, start
//     -> inst_out those 3 words on 3 consecutive cycles, issue_addr 0,1,2, then NOP, valid=0, done=1.
//  2 prog_len=9, halt on 4th valid cycle (issue_addr=3)
//     -> next cycle NOP_INST, valid=0, busy=0, done=0, state IDLE.
//  3 load_we to addr 1 during RUN
//     -> load_err pulses 1 cycle, RAM[1] unchanged on replay, issue sequence uninterrupted.
//  4 Fill RAM with addr as data, prog_len=63, start
//     -> 64 valid words 0..63 in order, then done; issue_addr never exceeds 63.
//  5 Assert rst_n=0 mid-RUN (no clk edge)
//     -> outputs at reset values immediately; restart replays the original RAM words from addr 0.
//  6 start with load_we to addr 0 (data 0xDEADBEEF) on the same edge
//     -> first inst_out=0xDEADBEEF. With IFU_ISSUE_COUNT_EN and scenario 1: issue_cnt=3 at done.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Program-load and instruction-issue bundle between inst_fetch_unit and its driver.
// issue_cnt exists only when IFU_ISSUE_COUNT_EN is defined.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 6
);
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] prog_len;
    logic              start;
    logic              halt;
    logic [31:0]       inst_out;
    logic              inst_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              busy;
    logic              done;
    logic              load_err;
`ifdef IFU_ISSUE_COUNT_EN
    logic [31:0]       issue_cnt;
`endif

    modport master (
        output load_we, load_addr, load_data,
        output prog_len, start, halt,
        input  inst_out, inst_valid, issue_addr,
        input  busy, done, load_err
`ifdef IFU_ISSUE_COUNT_EN
        , input issue_cnt
`endif
    );

    modport slave (
        input  load_we, load_addr, load_data,
        input  prog_len, start, halt,
        output inst_out, inst_valid, issue_addr,
        output busy, done, load_err
`ifdef IFU_ISSUE_COUNT_EN
        , output issue_cnt
`endif
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Program RAM plus IDLE/RUN/DONE replay FSM feeding the core's Inst port.
// Optional IFU_ISSUE_COUNT_EN adds a saturating issued-word counter.
module inst_fetch_unit #(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_fetch_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0]       mem [DEPTH];
    logic              ram_we;
    logic              loadable;
    logic              start_acc;
    logic              step;
    logic [ADDR_W-1:0] nxt_addr;
    logic [31:0]       word0;

    assign loadable  = (state_q != S_RUN);
    assign ram_we    = bus.load_we && loadable;
    assign start_acc = bus.start && !bus.halt && loadable;
    assign step      = (state_q == S_RUN) && !bus.halt;
    assign nxt_addr  = addr_q + ADDR_W'(1);
    // A same-edge write to address 0 must be seen by the first issue.
    assign word0 = (ram_we && bus.load_addr == '0)
                 ? bus.load_data : mem[0];

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        err_d   = bus.load_we && !loadable;
        unique case (1'b1)
            bus.halt: begin
                state_d = S_IDLE;
                addr_d  = '0;
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
            start_acc: begin
                state_d = S_RUN;
                len_d   = bus.prog_len;
                addr_d  = '0;
                inst_d  = word0;
                valid_d = 1'b1;
            end
            step: begin
                if (addr_q == len_q) begin
                    state_d = S_DONE;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end else begin
                    addr_d = nxt_addr;
                    inst_d = mem[nxt_addr];
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Program contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.inst_out   = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.issue_addr = addr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_err   = err_q;

`ifdef IFU_ISSUE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if (valid_q && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.issue_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: load, replay, halt, load-in-run,
// full-depth replay, async reset mid-run, write-first start, prog_len latching.
module tb_inst_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] W0  = 32'h2001_0001;
    localparam logic [31:0] W1  = 32'h2002_0001;
    localparam logic [31:0] W2  = 32'h0021_0820;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    inst_fetch_unit_if #(.ADDR_W(6)) bus ();

    inst_fetch_unit #(
        .DEPTH(64),
        .ADDR_W(6),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_word(input logic [5:0] a, input logic [31:0] d);
        bus.load_we   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        @(negedge clk);
        bus.load_we   = 1'b0;
    endtask

    task automatic pulse_start(input logic [5:0] len);
        bus.prog_len = len;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic test_reset;
        n_total += 6;
        if (bus.inst_out !== NOP)
            $display("FAIL reset_inst got %h want %h", bus.inst_out, NOP);
        else n_pass++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL reset_valid got %b want 0", bus.inst_valid);
        else n_pass++;
        if (bus.issue_addr !== 6'd0)
            $display("FAIL reset_addr got %0d want 0", bus.issue_addr);
        else n_pass++;
        if (bus.busy !== 1'b0)
            $display("FAIL reset_busy got %b want 0", bus.busy);
        else n_pass++;
        if (bus.done !== 1'b0)
            $display("FAIL reset_done got %b want 0", bus.done);
        else n_pass++;
        if (bus.load_err !== 1'b0)
            $display("FAIL reset_err got %b want 0", bus.load_err);
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [31:0] exp [3];
        exp[0] = W0;
        exp[1] = W1;
        exp[2] = W2;
        load_word(6'd0, W0);
        load_word(6'd1, W1);
        load_word(6'd2, W2);
        pulse_start(6'd2);
        for (int i = 0; i < 3; i++) begin
            n_total += 4;
            if (bus.inst_out !== exp[i])
                $display("FAIL basic_inst[%0d] got %h want %h", i, bus.inst_out, exp[i]);
            else n_pass++;
            if (bus.issue_addr !== 6'(i))
                $display("FAIL basic_addr[%0d] got %0d want %0d", i, bus.issue_addr, i);
            else n_pass++;
            if (bus.inst_valid !== 1'b1)
                $display("FAIL basic_valid[%0d] got %b want 1", i, bus.inst_valid);
            else n_pass++;
            if (bus.busy !== 1'b1)
                $display("FAIL basic_busy[%0d] got %b want 1", i, bus.busy);
            else n_pass++;
            @(negedge clk);
        end
        n_total += 4;
        if (bus.inst_out !== NOP)
            $display("FAIL basic_end_inst got %h want %h", bus.inst_out, NOP);
        else n_pass++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL basic_end_valid got %b want 0", bus.inst_valid);
        else n_pass++;
        if (bus.done !== 1'b1)
            $display("FAIL basic_end_done got %b want 1", bus.done);
        else n_pass++;
        if (bus.busy !== 1'b0)
            $display("FAIL basic_end_busy got %b want 0", bus.busy);
        else n_pass++;
`ifdef IFU_ISSUE_COUNT_EN
        n_total++;
        if (bus.issue_cnt !== 32'd3)
            $display("FAIL basic_cnt got %0d want 3", bus.issue_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_halt;
        for (int i = 0; i < 10; i++) load_word(6'(i), 32'h100 + i);
        pulse_start(6'd9);
        repeat (3) @(negedge clk);
        n_total += 2;
        if (bus.issue_addr !== 6'd3)
            $display("FAIL halt_pre_addr got %0d want 3", bus.issue_addr);
        else n_pass++;
        if (bus.inst_out !== 32'h103)
            $display("FAIL halt_pre_inst got %h want 00000103", bus.inst_out);
        else n_pass++;
        bus.halt = 1'b1;
        @(negedge clk);
        bus.halt = 1'b0;
        n_total += 4;
        if (bus.inst_out !== NOP)
            $display("FAIL halt_inst got %h want %h", bus.inst_out, NOP);
        else n_pass++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL halt_valid got %b want 0", bus.inst_valid);
        else n_pass++;
        if (bus.busy !== 1'b0)
            $display("FAIL halt_busy got %b want 0", bus.busy);
        else n_pass++;
        if (bus.done !== 1'b0)
            $display("FAIL halt_done got %b want 0", bus.done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL halt_stay_idle got %b want 0", bus.inst_valid);
        else n_pass++;
    endtask

    task automatic test_load_in_run;
        load_word(6'd0, W0);
        load_word(6'd1, W1);
        load_word(6'd2, W2);
        pulse_start(6'd2);
        bus.load_we   = 1'b1;
        bus.load_addr = 6'd1;
        bus.load_data = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.load_we   = 1'b0;
        n_total += 3;
        if (bus.load_err !== 1'b1)
            $display("FAIL lrun_err got %b want 1", bus.load_err);
        else n_pass++;
        if (bus.inst_out !== W1)
            $display("FAIL lrun_inst1 got %h want %h", bus.inst_out, W1);
        else n_pass++;
        if (bus.issue_addr !== 6'd1)
            $display("FAIL lrun_addr1 got %0d want 1", bus.issue_addr);
        else n_pass++;
        @(negedge clk);
        n_total += 2;
        if (bus.load_err !== 1'b0)
            $display("FAIL lrun_err_clr got %b want 0", bus.load_err);
        else n_pass++;
        if (bus.inst_out !== W2)
            $display("FAIL lrun_inst2 got %h want %h", bus.inst_out, W2);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b1)
            $display("FAIL lrun_done got %b want 1", bus.done);
        else n_pass++;
        pulse_start(6'd2);
        @(negedge clk);
        n_total++;
        if (bus.inst_out !== W1)
            $display("FAIL lrun_replay got %h want %h", bus.inst_out, W1);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_depth;
        for (int i = 0; i < 64; i++) load_word(6'(i), 32'(i));
        pulse_start(6'd63);
        for (int i = 0; i < 64; i++) begin
            n_total += 3;
            if (bus.inst_out !== 32'(i))
                $display("FAIL full_inst[%0d] got %h want %h", i, bus.inst_out, 32'(i));
            else n_pass++;
            if (bus.issue_addr !== 6'(i))
                $display("FAIL full_addr[%0d] got %0d want %0d", i, bus.issue_addr, i);
            else n_pass++;
            if (bus.inst_valid !== 1'b1)
                $display("FAIL full_valid[%0d] got %b want 1", i, bus.inst_valid);
            else n_pass++;
            @(negedge clk);
        end
        n_total += 3;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL full_end_valid got %b want 0", bus.inst_valid);
        else n_pass++;
        if (bus.done !== 1'b1)
            $display("FAIL full_end_done got %b want 1", bus.done);
        else n_pass++;
        if (bus.inst_out !== NOP)
            $display("FAIL full_end_inst got %h want %h", bus.inst_out, NOP);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        pulse_start(6'd63);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total += 4;
        if (bus.inst_out !== NOP)
            $display("FAIL rmid_inst got %h want %h", bus.inst_out, NOP);
        else n_pass++;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL rmid_valid got %b want 0", bus.inst_valid);
        else n_pass++;
        if (bus.busy !== 1'b0)
            $display("FAIL rmid_busy got %b want 0", bus.busy);
        else n_pass++;
        if (bus.issue_addr !== 6'd0)
            $display("FAIL rmid_addr got %0d want 0", bus.issue_addr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(6'd63);
        n_total += 2;
        if (bus.inst_out !== 32'd0)
            $display("FAIL rmid_replay0 got %h want 00000000", bus.inst_out);
        else n_pass++;
        if (bus.inst_valid !== 1'b1)
            $display("FAIL rmid_replay_valid got %b want 1", bus.inst_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.inst_out !== 32'd1)
            $display("FAIL rmid_replay1 got %h want 00000001", bus.inst_out);
        else n_pass++;
        bus.halt = 1'b1;
        @(negedge clk);
        bus.halt = 1'b0;
    endtask

    task automatic test_write_first;
        bus.prog_len  = 6'd1;
        bus.start     = 1'b1;
        bus.load_we   = 1'b1;
        bus.load_addr = 6'd0;
        bus.load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.load_we   = 1'b0;
        n_total += 2;
        if (bus.inst_out !== 32'hDEAD_BEEF)
            $display("FAIL wfirst_inst got %h want deadbeef", bus.inst_out);
        else n_pass++;
        if (bus.load_err !== 1'b0)
            $display("FAIL wfirst_err got %b want 0", bus.load_err);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.inst_out !== 32'd1)
            $display("FAIL wfirst_next got %h want 00000001", bus.inst_out);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.done !== 1'b1)
            $display("FAIL wfirst_done got %b want 1", bus.done);
        else n_pass++;
    endtask

    task automatic test_len_latch;
        pulse_start(6'd2);
        bus.prog_len = 6'd5;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        n_total++;
        if (bus.issue_addr !== 6'd1)
            $display("FAIL latch_start_ignored got %0d want 1", bus.issue_addr);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.inst_out !== 32'd2)
            $display("FAIL latch_inst2 got %h want 00000002", bus.inst_out);
        else n_pass++;
        @(negedge clk);
        n_total += 2;
        if (bus.inst_valid !== 1'b0)
            $display("FAIL latch_valid got %b want 0", bus.inst_valid);
        else n_pass++;
        if (bus.done !== 1'b1)
            $display("FAIL latch_done got %b want 1", bus.done);
        else n_pass++;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.load_we   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.halt      = 1'b0;
        #1;
        test_reset;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic;
        test_halt;
        test_load_in_run;
        test_full_depth;
        test_reset_mid_run;
        test_write_first;
        test_len_latch;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
